uart_beep_ctrl: RTL
===================

# uart_beep_ctrl

Command parser and buzzer driver that consumes bytes from the UART receiver and produces a square-wave beep output. It sits directly downstream of the receiver's `uart_done`/`uart_data` pair. It decodes fixed-length command frames that set tone pitch and duration, then starts or stops a tone. It drives the board buzzer pin and reports per-frame status strobes.

## Interface
- `CLK_FREQ`, 12000000: system clock in Hz; ms tick period is `MS_CNT = CLK_FREQ/1000` clocks.
- `DUR_DEFAULT`, 200: tone duration in ms loaded at reset.
- `sys_clk` in 1: system clock; single clock domain.
- `sys_rst` in 1: reset, synchronous, active-high.
- `uart_done` in 1: byte-valid from the receiver; may stay high for several cycles.
- `uart_data` in 8: received byte; valid while `uart_done` is high.
- `beep` out 1: buzzer square wave.
- `busy` out 1: high while a tone is playing.
- `frame_ok` out 1: one-cycle pulse when a valid frame has executed.
- `frame_err` out 1: one-cycle pulse when a complete frame is rejected.

## Operation
- Byte strobe is `uart_done & ~done_d`, where `done_d` is `uart_done` registered. Exactly one byte is accepted per `uart_done` high period, in the same cycle as its rising edge.
- Frame format: `0xA5`, CMD, P_HI, P_LO, then CHK (CHK only with the macro). P = {P_HI, P_LO}, unsigned 16 bit.
- Parser FSM states:
  - IDLE: a strobe with `0xA5` moves to CMD; any other byte is discarded silently, with no `frame_err`.
  - CMD: the strobe latches CMD and moves to PH.
  - PH: the strobe latches P_HI and moves to PL.
  - PL: the strobe latches P_LO, then moves to CHK if the macro is defined, otherwise to EXEC.
  - CHK: the strobe latches CHK and moves to EXEC.
  - EXEC: one cycle; executes or rejects the frame and always returns to IDLE.
  - There is no inter-byte timeout. The parser waits indefinitely in any state.
- Commands (evaluated in EXEC):
  - `0x01` PLAY: P is the half-period in clocks. P=0 is rejected with `frame_err`. Starts a tone with the currently stored duration. A PLAY while `busy` restarts the tone with the new P and the full duration.
  - `0x02` SETDUR: stores P as the duration in ms for subsequent PLAYs. It does not alter a tone already playing. P=0 means play until STOP.
  - `0x03` STOP: ends the tone. P is ignored. A STOP when idle is still `frame_ok`.
  - Any other CMD: `frame_err`, with no effect on the tone or stored duration.
- Tone generator:
  - The half-period counter counts 0..P-1 and toggles `beep` on wrap.
  - The ms prescaler counts 0..MS_CNT-1. On each wrap, the remaining-ms counter decrements.
  - When remaining reaches 0 (duration ≠ 0), `beep` goes to 0 and `busy` goes to 0.
  - Counters are 16 bit. The prescaler is sized by `$clog2(MS_CNT)`.

## Timing
- Reset values: `beep`=0, `busy`=0, `frame_ok`=0, `frame_err`=0. The parser goes to IDLE and the stored duration to `DUR_DEFAULT`.
- Reset mid-frame or mid-tone aborts everything in the same edge. No strobes are emitted.
- EXEC is entered on the edge after the final byte's strobe. `frame_ok`/`frame_err` are asserted for the single cycle following EXEC.
- PLAY: `beep`=1 and `busy`=1 in the same cycle as `frame_ok`. The first toggle to 0 occurs P cycles later. Output period is 2P cycles.
- Duration D≠0: `busy` is high for exactly D×MS_CNT cycles, then `busy` and `beep` fall together.
- STOP: `beep`=0 and `busy`=0 in the same cycle as `frame_ok`.
- If a tone's natural end coincides with a PLAY executing, PLAY wins: the tone restarts.
- A `uart_done` rising edge during EXEC is accepted as the first byte of the next frame, judged by IDLE rules.

## Configuration
- `BEEP_CHECKSUM_EN` defined: the frame is 5 bytes. CHK must equal CMD^P_HI^P_LO. A mismatch gives `frame_err` with no effect.
- Not defined: the frame is 4 bytes and the CHK state is absent from the FSM.

## Test plan
- CLK_FREQ=12000 (MS_CNT=12), no macro. Send A5 01 00 05 → `frame_ok`; `beep` toggles every 5 cycles; `busy` high for exactly 2400 cycles (200 ms), then `beep`=`busy`=0.
- A5 02 00 00, then A5 01 00 03 → tone with period 6 never ends. Then A5 03 00 00 → `beep`=`busy`=0 in the `frame_ok` cycle.
- Hold `uart_done` high 50 cycles per byte; send 00 37 A5 01 00 04 → one frame accepted; leading bytes ignored with no `frame_err`.
- A5 07 12 34 → `frame_err`, tone state unchanged. A5 01 00 00 → `frame_err`.
- Assert `sys_rst` for 1 cycle after A5 01 → the next frame A5 01 00 02 parses cleanly from IDLE.
- With `BEEP_CHECKSUM_EN`: A5 01 00 05 04 → `frame_ok`; A5 01 00 05 05 → `frame_err`.

Source files
------------

// File: rtl/uart_beep_ctrl_if.sv
// rtl/uart_beep_ctrl_if.sv - received-byte handshake from the UART receiver into the beep controller
interface uart_beep_ctrl_if;
    logic       uart_done;
    logic [7:0] uart_data;

    modport master (output uart_done, output uart_data);
    modport slave  (input  uart_done, input  uart_data);
endinterface

// File: rtl/uart_beep_ctrl.sv
// rtl/uart_beep_ctrl.sv - UART command-frame parser driving a square-wave buzzer
// Optional feature macro: BEEP_CHECKSUM_EN (adds a trailing CMD^P_HI^P_LO check byte).
module uart_beep_ctrl #(
    parameter int CLK_FREQ    = 12000000,
    parameter int DUR_DEFAULT = 200
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    uart_beep_ctrl_if.slave rx,
    output logic            beep,
    output logic            busy,
    output logic            frame_ok,
    output logic            frame_err
);
    localparam int            MS_CNT   = CLK_FREQ / 1000;
    localparam int            PW       = (MS_CNT > 1) ? $clog2(MS_CNT) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(MS_CNT - 1);
    localparam logic [7:0]    SYNC     = 8'hA5;

`ifdef BEEP_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_PH, S_PL, S_CHK, S_EXEC} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_PH, S_PL, S_EXEC} state_t;
`endif

    state_t        state_q, state_d;
    logic          done_q;
    logic [7:0]    cmd_q, cmd_d, phi_q, phi_d, plo_q, plo_d;
    logic [15:0]   p_val;
    logic          frame_good;
    logic          exec_play, exec_set, exec_stop, exec_err;
    logic          strobe;
    logic          beep_q, busy_q, ok_q, err_q;
    logic [15:0]   dur_q, half_q, hcnt_q, rem_q;
    logic [PW-1:0] pres_q;

    assign strobe = rx.uart_done & ~done_q;
    assign p_val  = {phi_q, plo_q};

`ifdef BEEP_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;
    assign frame_good = (chk_q == (cmd_q ^ phi_q ^ plo_q));
`else
    assign frame_good = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        phi_d     = phi_q;
        plo_d     = plo_q;
`ifdef BEEP_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        exec_play = 1'b0;
        exec_set  = 1'b0;
        exec_stop = 1'b0;
        exec_err  = 1'b0;
        case (state_q)
            S_IDLE: if (strobe && rx.uart_data == SYNC) state_d = S_CMD;
            S_CMD:  if (strobe) begin cmd_d = rx.uart_data; state_d = S_PH; end
            S_PH:   if (strobe) begin phi_d = rx.uart_data; state_d = S_PL; end
`ifdef BEEP_CHECKSUM_EN
            S_PL:   if (strobe) begin plo_d = rx.uart_data; state_d = S_CHK; end
            S_CHK:  if (strobe) begin chk_d = rx.uart_data; state_d = S_EXEC; end
`else
            S_PL:   if (strobe) begin plo_d = rx.uart_data; state_d = S_EXEC; end
`endif
            S_EXEC: begin
                // A byte arriving here opens the next frame under idle rules.
                state_d = (strobe && rx.uart_data == SYNC) ? S_CMD : S_IDLE;
                if (!frame_good) begin
                    exec_err = 1'b1;
                end else begin
                    case (cmd_q)
                        8'h01:   if (p_val == 16'd0) exec_err = 1'b1; else exec_play = 1'b1;
                        8'h02:   exec_set  = 1'b1;
                        8'h03:   exec_stop = 1'b1;
                        default: exec_err  = 1'b1;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            cmd_q   <= 8'd0;
            phi_q   <= 8'd0;
            plo_q   <= 8'd0;
`ifdef BEEP_CHECKSUM_EN
            chk_q   <= 8'd0;
`endif
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            beep_q  <= 1'b0;
            busy_q  <= 1'b0;
            dur_q   <= 16'(DUR_DEFAULT);
            half_q  <= 16'd0;
            hcnt_q  <= 16'd0;
            rem_q   <= 16'd0;
            pres_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= rx.uart_done;
            cmd_q   <= cmd_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
`ifdef BEEP_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
            ok_q    <= exec_play | exec_set | exec_stop;
            err_q   <= exec_err;
            if (exec_set) dur_q <= p_val;
            // PLAY takes priority over a tone ending naturally in the same cycle.
            if (exec_play) begin
                half_q <= p_val;
                hcnt_q <= 16'd0;
                pres_q <= '0;
                rem_q  <= dur_q;
                beep_q <= 1'b1;
                busy_q <= 1'b1;
            end else if (exec_stop) begin
                beep_q <= 1'b0;
                busy_q <= 1'b0;
            end else if (busy_q) begin
                if (hcnt_q == half_q - 16'd1) begin
                    hcnt_q <= 16'd0;
                    beep_q <= ~beep_q;
                end else begin
                    hcnt_q <= hcnt_q + 16'd1;
                end
                // rem_q of zero means the tone runs until STOP.
                if (pres_q == PRE_LAST) begin
                    pres_q <= '0;
                    if (rem_q != 16'd0) begin
                        rem_q <= rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            beep_q <= 1'b0;
                            busy_q <= 1'b0;
                        end
                    end
                end else begin
                    pres_q <= pres_q + 1'b1;
                end
            end
        end
    end

    assign beep      = beep_q;
    assign busy      = busy_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
endmodule
